// File: rtl/gen_shift_pkg.sv
// Shared types and helpers for the generic shift target.
package gen_shift_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} gst_state_t;

  localparam int GS_BITS_W = 3;

  // Bit position within a byte for the cnt-th shifted bit.
  function automatic logic [GS_BITS_W-1:0] gs_bit_idx(input logic [GS_BITS_W-1:0] cnt,
                                                      input bit lsb_first);
    return lsb_first ? cnt : ~cnt;
  endfunction
endpackage

// File: rtl/gen_shift_sync.sv
// Multi-stage pad synchronizer with a selectable reset value.
module gen_shift_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain;

  // Shift the pad level through the chain; reset to the pad's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {SYNC_STAGES{RST_VAL}};
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/gen_shift_target.sv
// Responder end of the generic shift interface: oversamples SCLK/CS/DIN/AUX,
// assembles RX words onto a stream port and shifts TX bytes out on DOUT.
module gen_shift_target
  import gen_shift_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_IDLE     = 8'hFF,
  parameter bit         LSB_FIRST   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk_i,
  input  logic                 cs_n_i,
  input  logic                 din_i,
  input  logic                 aux_i,
  output logic                 dout_o,
  output logic                 dout_t,
  output logic [7:0]           rx_tdata,
  output logic [7:0]           rx_taux,
  output logic [GS_BITS_W-1:0] rx_tnbits,
  output logic                 rx_tlast,
  output logic                 rx_tvalid,
  input  logic                 rx_tready,
  input  logic [7:0]           tx_tdata,
  input  logic                 tx_tvalid,
  output logic                 tx_tready,
  input  logic                 clr_i,
  output logic                 overflow_o,
  output logic                 underrun_o,
  output logic                 active_o
);
  localparam logic [GS_BITS_W-1:0] FIRST_IDX = gs_bit_idx('0, LSB_FIRST);

  logic sclk_s, cs_s, din_s, aux_s, sclk_q, cs_q;

  gen_shift_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk, .rst_n, .d(sclk_i), .q(sclk_s));
  gen_shift_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk, .rst_n, .d(cs_n_i), .q(cs_s));
  gen_shift_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din  (.clk, .rst_n, .d(din_i),  .q(din_s));
  gen_shift_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_aux  (.clk, .rst_n, .d(aux_i),  .q(aux_s));

  // Delayed copies of the synced clock/select for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
    end
  end

  gst_state_t           state;
  logic [GS_BITS_W-1:0] cnt, idx;
  logic [7:0]           tx_shift, rx_d, rx_a, rx_d_nxt, rx_a_nxt, pend_d, pend_a, tx_pick;
  logic                 pend_vld;
  logic                 cs_fall, cs_rise, rise_ok, fall_ok, wrap, load_now;
  logic                 emit, e_last;
  logic [7:0]           e_d, e_a;
  logic [GS_BITS_W-1:0] e_n;

  assign cs_fall  = ~cs_s & cs_q;
  assign cs_rise  = cs_s & ~cs_q;
  // Edges only count inside a frame; cs high masks stray clocks.
  assign rise_ok  = (state == SHIFT) && !cs_s && sclk_s && !sclk_q;
  assign fall_ok  = (state == SHIFT) && !cs_s && !sclk_s && sclk_q;
  assign wrap     = rise_ok && (cnt == '1);
  assign load_now = (state == LOAD) || wrap;
  assign idx      = gs_bit_idx(cnt, LSB_FIRST);
  assign tx_pick  = tx_tvalid ? tx_tdata : TX_IDLE;

  // Next RX shift contents with the current din/aux bit dropped into place.
  always_comb begin
    rx_d_nxt      = rx_d;
    rx_a_nxt      = rx_a;
    rx_d_nxt[idx] = din_s;
    rx_a_nxt[idx] = aux_s;
  end

  // Decide whether a word leaves the shifter this cycle, and what it holds.
  always_comb begin
    emit   = 1'b0;
    e_d    = pend_d;
    e_a    = pend_a;
    e_n    = '1;
    e_last = 1'b0;
    if (state != IDLE && cs_rise) begin
      if (cnt != '0) begin
        emit   = 1'b1;
        e_d    = rx_d;
        e_a    = rx_a;
        e_n    = cnt - 3'd1;
        e_last = 1'b1;
      end else if (pend_vld) begin
        emit   = 1'b1;
        e_last = 1'b1;
      end
    end else if (rise_ok && pend_vld) begin
      emit = 1'b1;
    end
  end

  // Frame FSM: TX loading, bit shifting, DOUT drive and underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dout_o     <= 1'b0;
      dout_t     <= 1'b1;
      tx_tready  <= 1'b0;
      underrun_o <= 1'b0;
      active_o   <= 1'b0;
      cnt        <= '0;
      tx_shift   <= '0;
      rx_d       <= '0;
      rx_a       <= '0;
      pend_vld   <= 1'b0;
      pend_d     <= '0;
      pend_a     <= '0;
    end else begin
      tx_tready <= 1'b0;
      active_o  <= ~cs_s;
      if (load_now && !tx_tvalid) underrun_o <= 1'b1;
      else if (clr_i)             underrun_o <= 1'b0;

      if (load_now) begin
        tx_shift  <= tx_pick;
        tx_tready <= tx_tvalid;
      end

      case (state)
        IDLE: if (cs_fall) state <= LOAD;
        LOAD: begin
          dout_t   <= 1'b0;
          dout_o   <= tx_pick[FIRST_IDX];
          cnt      <= '0;
          rx_d     <= '0;
          rx_a     <= '0;
          pend_vld <= 1'b0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (rise_ok) begin
            cnt <= cnt + 3'd1;
            if (wrap) begin
              pend_vld <= 1'b1;
              pend_d   <= rx_d_nxt;
              pend_a   <= rx_a_nxt;
              rx_d     <= '0;
              rx_a     <= '0;
            end else begin
              pend_vld <= 1'b0;
              rx_d     <= rx_d_nxt;
              rx_a     <= rx_a_nxt;
            end
          end
          // After a wrap tx_shift already holds the new byte and cnt is 0.
          if (fall_ok) dout_o <= tx_shift[idx];
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE && cs_rise) begin
        state    <= IDLE;
        dout_t   <= 1'b1;
        cnt      <= '0;
        pend_vld <= 1'b0;
      end
    end
  end

  // RX holding register: accept when empty or draining, otherwise drop and flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_tvalid  <= 1'b0;
      rx_tdata   <= '0;
      rx_taux    <= '0;
      rx_tnbits  <= '0;
      rx_tlast   <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (!rx_tvalid || rx_tready) begin
        rx_tvalid <= emit;
        if (emit) begin
          rx_tdata  <= e_d;
          rx_taux   <= e_a;
          rx_tnbits <= e_n;
          rx_tlast  <= e_last;
        end
      end
      if (emit && rx_tvalid && !rx_tready) overflow_o <= 1'b1;
      else if (clr_i)                      overflow_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gen_shift_target.sv
// Directed bench for gen_shift_target: a bit-banged initiator drives frames,
// expected RX words go into per-DUT queues and are checked by monitors.
module tb_gen_shift_target;
  localparam int H = 8;  // initiator half-period in clk cycles

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] a;
    logic [2:0] n;
    logic       l;
  } rxw_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sclk = 1'b0, cs0 = 1'b1, cs1 = 1'b1, din = 1'b0, aux = 1'b0, clr = 1'b0;
  logic rdy0 = 1'b1, rdy1 = 1'b1;
  logic [7:0] tx_d = 8'h00;
  logic tx_v = 1'b0;

  logic dout0, dt0, v0, l0, txr0, ov0, un0, act0;
  logic [7:0] d0, a0;
  logic [2:0] n0;
  logic dout1, dt1, v1, l1, txr1, ov1, un1, act1;
  logic [7:0] d1, a1;
  logic [2:0] n1;

  gen_shift_target #(.SYNC_STAGES(2), .TX_IDLE(8'hFF), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .cs_n_i(cs0), .din_i(din), .aux_i(aux),
    .dout_o(dout0), .dout_t(dt0), .rx_tdata(d0), .rx_taux(a0), .rx_tnbits(n0),
    .rx_tlast(l0), .rx_tvalid(v0), .rx_tready(rdy0), .tx_tdata(tx_d), .tx_tvalid(tx_v),
    .tx_tready(txr0), .clr_i(clr), .overflow_o(ov0), .underrun_o(un0), .active_o(act0));

  gen_shift_target #(.SYNC_STAGES(2), .TX_IDLE(8'hFF), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .cs_n_i(cs1), .din_i(din), .aux_i(aux),
    .dout_o(dout1), .dout_t(dt1), .rx_tdata(d1), .rx_taux(a1), .rx_tnbits(n1),
    .rx_tlast(l1), .rx_tvalid(v1), .rx_tready(rdy1), .tx_tdata(tx_d), .tx_tvalid(tx_v),
    .tx_tready(txr1), .clr_i(clr), .overflow_o(ov1), .underrun_o(un1), .active_o(act1));

  rxw_t       q0[$], q1[$];
  logic [7:0] txq[$], doutq[$];
  int total = 0, bad = 0;

  function automatic rxw_t mk(input logic [7:0] d, input logic [7:0] a,
                              input logic [2:0] n, input logic l);
    rxw_t w;
    w.d = d; w.a = a; w.n = n; w.l = l;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // TX reply source: retire the head byte when the DUT pulses tx_tready.
  always @(negedge clk) begin
    if ((txr0 || txr1) && txq.size() > 0) void'(txq.pop_front());
    tx_v = (txq.size() > 0);
    tx_d = tx_v ? txq[0] : 8'h00;
  end

  // RX monitors: compare every accepted word against the scoreboard head.
  always @(negedge clk) begin
    if (v0 && rdy0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL rx0_unexpected: got %0h want none", {d0, a0, n0, l0});
      end else chk("rx0_word", {d0, a0, n0, l0}, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (v1 && rdy1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL rx1_unexpected: got %0h want none", {d1, a1, n1, l1});
      end else chk("rx1_word", {d1, a1, n1, l1}, q1.pop_front());
    end
  end

  // One framed transfer of nb bits; DOUT bits are reassembled in the same order.
  task automatic xfer(input int sel, input int nb, input logic [31:0] dv,
                      input logic [31:0] av, input bit msb);
    logic [31:0] got;
    int pos;
    got = '0;
    @(negedge clk);
    if (sel == 0) cs0 = 1'b0; else cs1 = 1'b0;
    for (int i = 0; i < nb; i++) begin
      pos = (i / 8) * 8 + (msb ? 7 - (i % 8) : (i % 8));
      din = dv[pos];
      aux = av[pos];
      repeat (H) @(negedge clk);
      got[pos] = (sel == 0) ? dout0 : dout1;
      if (i == 0) begin
        chk("active_in_frame", (sel == 0) ? act0 : act1, 1);
        chk("dout_t_in_frame", (sel == 0) ? dt0 : dt1, 0);
      end
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (H) @(negedge clk);
    cs0 = 1'b1; cs1 = 1'b1; din = 1'b0; aux = 1'b0;
    repeat (H + 4) @(negedge clk);
    for (int b = 0; b < nb / 8; b++) begin
      if (doutq.size() == 0) begin
        total++; bad++;
        $display("FAIL dout_byte: got %0h want none", got[b*8 +: 8]);
      end else chk("dout_byte", got[b*8 +: 8], doutq.pop_front());
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dout_t", dt0, 1);
    chk("rst_dout_o", dout0, 0);
    chk("rst_rx_tvalid", v0, 0);
    chk("rst_tx_tready", txr0, 0);
    chk("rst_overflow", ov0, 0);
    chk("rst_underrun", un0, 0);
    chk("rst_active", act0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single byte, reply 0x5A; end-of-byte reload finds no data
    txq.push_back(8'h5A); doutq.push_back(8'h5A);
    q0.push_back(mk(8'hA5, 8'h3C, 3'd7, 1'b1));
    xfer(0, 8, 32'hA5, 32'h3C, 1'b0);
    chk("t1_underrun", un0, 1);

    // 2: three bytes, only two replies available
    pulse_clr();
    chk("t2_underrun_cleared", un0, 0);
    txq.push_back(8'h10); txq.push_back(8'h11);
    doutq.push_back(8'h10); doutq.push_back(8'h11); doutq.push_back(8'hFF);
    q0.push_back(mk(8'h01, 8'h00, 3'd7, 1'b0));
    q0.push_back(mk(8'h02, 8'h00, 3'd7, 1'b0));
    q0.push_back(mk(8'h03, 8'h00, 3'd7, 1'b1));
    xfer(0, 24, 32'h030201, 32'h0, 1'b0);
    chk("t2_underrun", un0, 1);

    // 3: 11-bit frame -> full byte then 3-bit partial
    doutq.push_back(8'hFF);
    q0.push_back(mk(8'hFF, 8'h00, 3'd7, 1'b0));
    q0.push_back(mk(8'h07, 8'h00, 3'd2, 1'b1));
    xfer(0, 11, 32'h7FF, 32'h0, 1'b0);

    // 4: consumer stalled -> second word dropped
    rdy0 = 1'b0;
    doutq.push_back(8'hFF); doutq.push_back(8'hFF);
    q0.push_back(mk(8'hC3, 8'h00, 3'd7, 1'b0));
    xfer(0, 16, 32'h3CC3, 32'h0, 1'b0);
    chk("t4_overflow", ov0, 1);
    chk("t4_held_valid", v0, 1);
    chk("t4_held_data", d0, 8'hC3);
    @(posedge clk); #1 rdy0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_drained", v0, 0);
    pulse_clr();
    chk("t4_overflow_cleared", ov0, 0);

    // 5: reset in the middle of a frame
    @(negedge clk); cs0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 1'b1;
      repeat (H) @(negedge clk); sclk = 1'b1;
      repeat (H) @(negedge clk); sclk = 1'b0;
    end
    rst_n = 1'b0;
    #1 chk("t5_dout_t_async", dt0, 1);
    cs0 = 1'b1; din = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_no_rx", v0, 0);
    chk("t5_underrun_reset", un0, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_idle_after_reset", act0, 0);
    doutq.push_back(8'hFF);
    q0.push_back(mk(8'h81, 8'h00, 3'd7, 1'b1));
    xfer(0, 8, 32'h81, 32'h0, 1'b0);

    // 6: MSB-first instance
    txq.push_back(8'h01); doutq.push_back(8'h01);
    q1.push_back(mk(8'h80, 8'h00, 3'd7, 1'b1));
    xfer(1, 8, 32'h80, 32'h0, 1'b1);

    for (int k = 0; k < 200 && (q0.size() > 0 || q1.size() > 0); k++) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("dout_q_drained", doutq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
